// File: rtl/mic_level_pkg.sv
// Shared widths and default quantiser settings for the microphone peak-level block.
package mic_level_pkg;
  localparam int MIC_W     = 12;
  localparam int LEVEL_W   = 4;
  localparam int LEVEL_MAX = 15;
  localparam int LED_W     = 16;

  localparam int DEF_THRESH0   = 2175;
  localparam int DEF_STEP_LOG2 = 7;
endpackage

// File: rtl/level_quantizer.sv
// Combinational peak-to-level map plus thermometer and BCD decode of a display level.
// The display level is a separate input so a held level can drive the decoders.
module level_quantizer
  import mic_level_pkg::*;
#(
  parameter int THRESH0   = DEF_THRESH0,
  parameter int STEP_LOG2 = DEF_STEP_LOG2
) (
  input  logic [MIC_W-1:0]   peak_i,
  input  logic [LEVEL_W-1:0] disp_lvl_i,
  output logic [LEVEL_W-1:0] raw_lvl_o,
  output logic [LED_W-1:0]   led_bar_o,
  output logic [3:0]         digit_tens_o,
  output logic [3:0]         digit_ones_o
);
  localparam logic [MIC_W:0] TH0   = (MIC_W+1)'(THRESH0);
  localparam logic [MIC_W:0] TH1   = (MIC_W+1)'(THRESH0 + 1);
  localparam logic [MIC_W:0] LMAX  = (MIC_W+1)'(LEVEL_MAX);

  logic [MIC_W:0]   pk_ext;
  logic [MIC_W:0]   diff;
  logic [MIC_W:0]   steps;
  logic [LED_W:0]   one_hot;
  logic [LEVEL_W:0] lvl_p1;

  // 13-bit arithmetic: the subtraction is only used when peak exceeds THRESH0, so it never wraps
  assign pk_ext = {1'b0, peak_i};
  assign diff   = pk_ext - TH1;
  assign steps  = diff >> STEP_LOG2;

  assign raw_lvl_o = (pk_ext <= TH0)  ? '0 :
                     (steps >= LMAX)  ? LEVEL_W'(LEVEL_MAX) :
                                        LEVEL_W'(steps + (MIC_W+1)'(1));

  assign lvl_p1       = {1'b0, disp_lvl_i} + (LEVEL_W+1)'(1);
  assign one_hot      = (LED_W+1)'(1) << lvl_p1;
  assign led_bar_o    = LED_W'(one_hot - (LED_W+1)'(1));
  assign digit_tens_o = (disp_lvl_i >= 4'd10) ? 4'd1 : 4'd0;
  assign digit_ones_o = (disp_lvl_i >= 4'd10) ? disp_lvl_i - 4'd10 : disp_lvl_i;
endmodule

// File: rtl/mic_peak_level.sv
// Windowed peak detector publishing a 0..15 volume level, LED bar and BCD digits per window.
// Optional peak-hold with slow decay is enabled by defining MIC_PEAK_HOLD_EN.
module mic_peak_level
  import mic_level_pkg::*;
#(
  parameter int WINDOW       = 10000,
  parameter int THRESH0      = DEF_THRESH0,
  parameter int STEP_LOG2    = DEF_STEP_LOG2,
  parameter int HOLD_WINDOWS = 4
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               sample_valid,
  input  logic [MIC_W-1:0]   sample,
  output logic [MIC_W-1:0]   peak,
  output logic [LEVEL_W-1:0] level,
  output logic               level_valid,
  output logic [LED_W-1:0]   led_bar,
  output logic [3:0]         digit_tens,
  output logic [3:0]         digit_ones
);
  logic [MIC_W-1:0]   run_max_q;
  logic [15:0]        win_cnt_q;
  logic               last_smp;
  logic [MIC_W-1:0]   close_pk;
  logic [LEVEL_W-1:0] raw_lvl;
  logic [LEVEL_W-1:0] disp_lvl_d;
  logic [LED_W-1:0]   led_d;
  logic [3:0]         tens_d;
  logic [3:0]         ones_d;

  assign last_smp = sample_valid && (win_cnt_q == 16'(WINDOW - 1));
  assign close_pk = (sample > run_max_q) ? sample : run_max_q;

  level_quantizer #(
    .THRESH0   (THRESH0),
    .STEP_LOG2 (STEP_LOG2)
  ) u_quant (
    .peak_i       (close_pk),
    .disp_lvl_i   (disp_lvl_d),
    .raw_lvl_o    (raw_lvl),
    .led_bar_o    (led_d),
    .digit_tens_o (tens_d),
    .digit_ones_o (ones_d)
  );

`ifdef MIC_PEAK_HOLD_EN
  logic [LEVEL_W-1:0] hold_lvl_q;
  logic [15:0]        hold_cnt_q;
  logic [15:0]        hold_cnt_d;

  // Raw level still beats the held one immediately; otherwise decay one step per HOLD_WINDOWS closes
  always_comb begin
    disp_lvl_d = hold_lvl_q;
    hold_cnt_d = hold_cnt_q + 16'd1;
    if (raw_lvl >= hold_lvl_q) begin
      disp_lvl_d = raw_lvl;
      hold_cnt_d = '0;
    end else if (hold_cnt_q == 16'(HOLD_WINDOWS - 1)) begin
      disp_lvl_d = hold_lvl_q - 4'd1;
      hold_cnt_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      hold_lvl_q <= '0;
      hold_cnt_q <= '0;
    end else if (last_smp) begin
      hold_lvl_q <= disp_lvl_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  assign disp_lvl_d = raw_lvl;
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      run_max_q   <= '0;
      win_cnt_q   <= '0;
      peak        <= '0;
      level       <= '0;
      level_valid <= 1'b0;
      led_bar     <= 16'h0001;
      digit_tens  <= '0;
      digit_ones  <= '0;
    end else begin
      level_valid <= 1'b0;
      if (last_smp) begin
        run_max_q   <= '0;
        win_cnt_q   <= '0;
        peak        <= close_pk;
        level       <= disp_lvl_d;
        level_valid <= 1'b1;
        led_bar     <= led_d;
        digit_tens  <= tens_d;
        digit_ones  <= ones_d;
      end else if (sample_valid) begin
        run_max_q <= close_pk;
        win_cnt_q <= win_cnt_q + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_mic_peak_level.sv
// Directed bench for mic_peak_level: a WINDOW=4 instance and a WINDOW=1 instance share clock and reset.
module tb_mic_peak_level;
  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        sv4 = 1'b0, sv1 = 1'b0;
  logic [11:0] s4 = '0, s1 = '0;

  logic [11:0] pk4, pk1;
  logic [3:0]  lv4, lv1, dt4, dt1, do4, do1;
  logic        vl4, vl1;
  logic [15:0] led4, led1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  mic_peak_level #(.WINDOW(4)) u4 (
    .CLK(CLK), .reset(reset), .sample_valid(sv4), .sample(s4),
    .peak(pk4), .level(lv4), .level_valid(vl4), .led_bar(led4),
    .digit_tens(dt4), .digit_ones(do4)
  );

  mic_peak_level #(.WINDOW(1), .HOLD_WINDOWS(2)) u1 (
    .CLK(CLK), .reset(reset), .sample_valid(sv1), .sample(s1),
    .peak(pk1), .level(lv1), .level_valid(vl1), .led_bar(led1),
    .digit_tens(dt1), .digit_ones(do1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge CLK); #1;
    reset = 1'b0;
  endtask

  task automatic strobe4(input logic [11:0] v);
    sv4 = 1'b1; s4 = v;
    @(posedge CLK); #1;
    sv4 = 1'b0;
  endtask

  task automatic strobe1(input logic [11:0] v);
    sv1 = 1'b1; s1 = v;
    @(posedge CLK); #1;
    sv1 = 1'b0;
  endtask

  task automatic check1(input string tag, input logic [11:0] v, input logic [3:0] lvl,
                        input logic [15:0] led, input logic [3:0] t, input logic [3:0] o);
    strobe1(v);
    check({tag, "_vld"}, vl1, 1'b1);
    check({tag, "_peak"}, pk1, v);
    check({tag, "_lvl"}, lv1, lvl);
    check({tag, "_led"}, led1, led);
    check({tag, "_dig"}, {dt1, do1}, {t, o});
  endtask

  initial begin
    @(posedge CLK); @(posedge CLK); #1;
    reset = 1'b0;

    // Reset values, then idle with no strobes
    check("rst_peak", pk4, 12'd0);
    check("rst_lvl", lv4, 4'd0);
    check("rst_led", led4, 16'h0001);
    check("rst_dig", {dt4, do4}, 8'h00);
    check("rst_vld", vl4, 1'b0);
    repeat (5) @(posedge CLK);
    #1;
    check("idle_vld", {vl4, vl1}, 2'b00);
    check("idle_lvl1", lv1, 4'd0);
    check("idle_led1", led1, 16'h0001);

    // WINDOW=4 basic window
    strobe4(12'd2048); strobe4(12'd2300); strobe4(12'd2100);
    check("w4a_novld", vl4, 1'b0);
    strobe4(12'd2048);
    check("w4a_vld", vl4, 1'b1);
    check("w4a_peak", pk4, 12'd2300);
    check("w4a_lvl", lv4, 4'd1);
    check("w4a_led", led4, 16'h0003);
    @(posedge CLK); #1;
    check("w4a_pulse", vl4, 1'b0);
    check("w4a_hold", lv4, 4'd1);

    // WINDOW=4 closing sample is the maximum 4095
    strobe4(12'd2048); strobe4(12'd2048); strobe4(12'd2048); strobe4(12'd4095);
    check("w4b_vld", vl4, 1'b1);
    check("w4b_peak", pk4, 12'd4095);
    check("w4b_lvl", lv4, 4'd15);
    check("w4b_led", led4, 16'hFFFF);
    check("w4b_dig", {dt4, do4}, 8'h15);

    // WINDOW=1 thresholds, ascending so a held level tracks raw
    check1("b0", 12'd0, 4'd0, 16'h0001, 4'd0, 4'd0);
    check1("b2175", 12'd2175, 4'd0, 16'h0001, 4'd0, 4'd0);
    check1("b2176", 12'd2176, 4'd1, 16'h0003, 4'd0, 4'd1);
    check1("b3455", 12'd3455, 4'd10, 16'h07FF, 4'd1, 4'd0);
    check1("b3456", 12'd3456, 4'd11, 16'h0FFF, 4'd1, 4'd1);

    // Reset mid-window, with a strobe coincident with reset that must be ignored
    do_reset();
    strobe4(12'd4000); strobe4(12'd2048);
    reset = 1'b1; sv4 = 1'b1; s4 = 12'd4095;
    @(posedge CLK); #1;
    reset = 1'b0; sv4 = 1'b0;
    check("mr_lvl_rst", lv4, 4'd0);
    strobe4(12'd2048); strobe4(12'd2048); strobe4(12'd2048);
    check("mr_novld", vl4, 1'b0);
    strobe4(12'd2048);
    check("mr_vld", vl4, 1'b1);
    check("mr_peak", pk4, 12'd2048);
    check("mr_lvl", lv4, 4'd0);
    check("mr_led", led4, 16'h0001);

    // Loud window followed by quiet ones on WINDOW=1
    do_reset();
    check1("h0", 12'd4095, 4'd15, 16'hFFFF, 4'd1, 4'd5);
`ifdef MIC_PEAK_HOLD_EN
    check1("h1", 12'd2048, 4'd15, 16'hFFFF, 4'd1, 4'd5);
    check1("h2", 12'd2048, 4'd14, 16'h7FFF, 4'd1, 4'd4);
    check1("h3", 12'd2048, 4'd14, 16'h7FFF, 4'd1, 4'd4);
    check1("h4", 12'd2048, 4'd13, 16'h3FFF, 4'd1, 4'd3);
`else
    check1("h1", 12'd2048, 4'd0, 16'h0001, 4'd0, 4'd0);
    check1("h2", 12'd2048, 4'd0, 16'h0001, 4'd0, 4'd0);
`endif
    @(posedge CLK); #1;
    check("h_pulse", vl1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
